conv_accum: RTL and testbench
=============================

Name: conv_accum

Overview:
Downstream consumer of the signed multiplier stage. Accumulates kernel_len consecutive signed products into one convolution output and adds a per-output bias. Applies an arithmetic right-shift cutoff and saturates to out_width before handing the pixel to the next stage over a valid/ready handshake.

Parameters:
mul_out_width, 16, width of each signed product input
acc_width, 32, width of signed accumulator and bias
out_width, 8, width of the signed saturated output
kernel_len, 9, products per output pixel (>=1)
shift, 4, arithmetic right shift applied before saturation (0..acc_width-1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  product valid
in_ready  output  1  block can accept a product this cycle
in_data  input  mul_out_width  signed product from multiplier stage
bias  input  acc_width  signed bias; sampled with the first product of each group
out_valid  output  1  out_data holds a finished pixel
out_ready  input  1  downstream accepts pixel
out_data  output  out_width  signed, shifted, saturated pixel
out_sat  output  1  pixel was clipped by saturation (qualified by out_valid)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0; in_ready=1 after release. Partial sum is discarded.
- Accept = in_valid & in_ready. in_ready = (state != OUTPUT), combinational from state only.
- FSM:
  - IDLE: on accept, acc <= bias + sext(in_data), cnt <= 1. If kernel_len==1 go to OUTPUT, else go to ACCUM.
  - ACCUM: on accept, acc_next = acc + sext(in_data) and cnt++. When the accepted product is number kernel_len, go to OUTPUT and register the result from acc_next. No accept: hold.
  - OUTPUT: out_valid=1; out_data and out_sat held stable. On out_ready go to IDLE and clear out_valid next cycle.
- Latency: out_valid rises the cycle after the kernel_len-th accept. Max throughput is one pixel per kernel_len+1 cycles.
- Bubbles: in_valid gaps in IDLE/ACCUM do not affect the result or cnt.
- Arithmetic:
  - Products are sign-extended to acc_width.
  - Accumulator overflow wraps two's complement; sizing acc_width is the integrator's responsibility.
  - Shift is arithmetic, truncating toward minus infinity (no rounding).
  - Saturation bounds: [-2^(out_width-1), 2^(out_width-1)-1]. out_sat=1 iff clamped.
- in_valid during OUTPUT is not consumed; the upstream must hold the product.
- bias is ignored except on the first accept of a group.

Optional Feature:
CONV_ACCUM_RELU_EN
- Defined: shifted value <0 forces out_data=0 before saturation. out_sat=0 for that case; only positive overflow sets out_sat.
- Undefined: full signed output as above.

Test Plan:
- kernel_len=9, shift=4, bias=0, nine products of 16, back-to-back -> out_data=9, out_sat=0; out_valid one cycle after ninth accept.
- Nine products of 1000, bias=0 (9000>>4=562) -> out_data=127, out_sat=1.
- Nine products of -1000, bias=0 (-563) -> out_data=-128, out_sat=1. With CONV_ACCUM_RELU_EN: out_data=0, out_sat=0.
- Floor check: bias=0, nine products of -2 (-18>>4) -> out_data=-2. Then bias=32, nine of -2 (14>>4) -> out_data=0.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable, no product lost. Next group (bias=16, nine products of 16, i.e. 160>>4) -> out_data=10.
- Reset asserted after 4 of 9 products, then a full group of 16s -> out_valid=0 during reset; result=9 with no carry-over.

Source files
------------

// File: rtl/conv_accum_if.sv
// Product-in / pixel-out handshake bundle for conv_accum.
interface conv_accum_if #(
  parameter int mul_out_width = 16,
  parameter int acc_width     = 32,
  parameter int out_width     = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic signed [mul_out_width-1:0] in_data;
  logic signed [acc_width-1:0]     bias;
  logic                            out_valid;
  logic                            out_ready;
  logic signed [out_width-1:0]     out_data;
  logic                            out_sat;

  modport master (
    output in_valid, in_data, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_accum.sv
// Accumulates kernel_len signed products plus bias, then shifts and saturates
// each pixel to out_width. Define CONV_ACCUM_RELU_EN to clamp negative results to zero.
module conv_accum #(
  parameter int mul_out_width = 16,
  parameter int acc_width     = 32,
  parameter int out_width     = 8,
  parameter int kernel_len    = 9,
  parameter int shift         = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_accum_if.slave  bus
);

  localparam int CNT_W = (kernel_len > 1) ? $clog2(kernel_len + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(kernel_len - 1);
  localparam logic signed [acc_width-1:0] SAT_MAX =
    {{(acc_width - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
  localparam logic signed [acc_width-1:0] SAT_MIN =
    {{(acc_width - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic signed [acc_width-1:0] r_acc;
  logic [CNT_W-1:0]            r_cnt;
  logic signed [out_width-1:0] r_out_data;
  logic                        r_out_sat;

  logic                        w_accept;
  logic                        w_last;
  logic signed [acc_width-1:0] w_in_sext;
  logic signed [acc_width-1:0] w_acc_nxt;
  logic signed [acc_width-1:0] w_shifted;
  logic signed [out_width-1:0] w_pix;
  logic                        w_pix_sat;

  assign bus.in_ready  = (r_state != S_OUTPUT);
  assign bus.out_valid = (r_state == S_OUTPUT);
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  assign w_accept  = bus.in_valid & bus.in_ready;
  assign w_in_sext = acc_width'(signed'(bus.in_data));

  // The first product of a group starts from the bias rather than the old sum.
  assign w_acc_nxt = (r_state == S_IDLE) ? (bus.bias + w_in_sext) : (r_acc + w_in_sext);
  assign w_shifted = w_acc_nxt >>> shift;

  assign w_last = ((r_state == S_IDLE)  && (kernel_len == 1)) ||
                  ((r_state == S_ACCUM) && (r_cnt == LAST_CNT));

  always_comb begin
    w_pix     = out_width'(w_shifted);
    w_pix_sat = 1'b0;
`ifdef CONV_ACCUM_RELU_EN
    if (w_shifted < 0) begin
      w_pix = '0;
    end else if (w_shifted > SAT_MAX) begin
      w_pix     = out_width'(SAT_MAX);
      w_pix_sat = 1'b1;
    end
`else
    if (w_shifted > SAT_MAX) begin
      w_pix     = out_width'(SAT_MAX);
      w_pix_sat = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      w_pix     = out_width'(SAT_MIN);
      w_pix_sat = 1'b1;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          if (w_last) w_state_nxt = S_OUTPUT;
          else        w_state_nxt = S_ACCUM;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        if (r_state == S_IDLE) r_cnt <= CNT_W'(1);
        else                   r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_out_data <= w_pix;
          r_out_sat  <= w_pix_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_accum.sv
// Directed checks of conv_accum: arithmetic, saturation, floor shift,
// backpressure and mid-group reset.
module tb_conv_accum;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_accum_if #(.mul_out_width(16), .acc_width(32), .out_width(8)) bus ();

  conv_accum #(
    .mul_out_width(16),
    .acc_width    (32),
    .out_width    (8),
    .kernel_len   (9),
    .shift        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input int val, input int b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(val);
    bus.bias     = b;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("push_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_group(input int val, input int b);
    for (int i = 0; i < 9; i++) push(val, (i == 0) ? b : 12345);
  endtask

  task automatic get_pixel(input string tag, input int exp_data, input int exp_sat);
    int t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_data"}, 32'(bus.out_data), exp_data);
    chk({tag, "_sat"}, 32'(bus.out_sat), exp_sat);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_sat", 32'(bus.out_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // 9*16 = 144 >> 4 = 9, with latency check around the ninth accept
    for (int i = 0; i < 8; i++) push(16, (i == 0) ? 0 : 777);
    chk("lat_before", 32'(bus.out_valid), 0);
    push(16, 777);
    chk("lat_after", 32'(bus.out_valid), 1);
    get_pixel("sum16", 9, 0);

    // 9000 >> 4 = 562 -> clamp high
    push_group(1000, 0);
    get_pixel("pos_sat", 127, 1);

    // -9000 >> 4 = -563 -> clamp low, or zero with ReLU
    push_group(-1000, 0);
`ifdef CONV_ACCUM_RELU_EN
    get_pixel("neg_sat", 0, 0);
`else
    get_pixel("neg_sat", -128, 1);
`endif

    // -18 >> 4 floors to -2; 32-18 = 14 >> 4 = 0
    push_group(-2, 0);
`ifdef CONV_ACCUM_RELU_EN
    get_pixel("floor_neg", 0, 0);
`else
    get_pixel("floor_neg", -2, 0);
`endif
    push_group(-2, 32);
    get_pixel("floor_bias", 0, 0);

    // Backpressure: pixel held while the next product waits upstream
    push_group(16, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd16;
    bus.bias     = 16;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_data", 32'(bus.out_data), 9);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_released", 32'(bus.in_ready), 1);
    push(16, 16);
    for (int i = 0; i < 8; i++) push(16, 999);
    get_pixel("bp_next", 10, 0);

    // Reset after 4 of 9 products; partial sum must not carry over
    for (int i = 0; i < 4; i++) push(100, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Bubbles between products must not change the result
    for (int i = 0; i < 9; i++) begin
      push(16, (i == 0) ? 0 : 555);
      if (i % 3 == 1) repeat (2) @(negedge clk);
    end
    get_pixel("post_rst", 9, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
